// File: rtl/nios_security_led_pkg.sv
// Shared constants and types for the Nios security LED output port.
// The register map is word addressed and has eight slots; slots 6 and 7 are reserved.
package nios_security_led_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_PERIOD_W = 24;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  typedef struct packed {
    logic        vld;
    logic [2:0]  addr;
    logic [31:0] data;
  } led_wr_req_t;

endpackage

// File: rtl/nios_security_blink_timer.sv
// Half-period blink timer that produces the phase bit used to invert the masked output bits.
// A period write clears cnt and phase on the same edge, and it takes priority over a terminal count.
module nios_security_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;
  logic                term;

  // The period is nonzero whenever term is used, so period-1 cannot wrap.
  assign term = (cnt == (period - PERIOD_W'(1)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load || (period == '0)) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (term) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/nios_security_led_out.sv
// Avalon-MM output port that provides a DATA register, atomic set/clear, and hardware blink of masked bits.
// readdata and out_port are registered. Reads return the register values from before any write in the same cycle.
module nios_security_led_out
  import nios_security_led_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter int          PERIOD_W    = DEF_PERIOD_W,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  led_wr_req_t         wr_req;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    mask_q;
  logic [PERIOD_W-1:0] period_q;
  logic [WIDTH-1:0]    wd;
  logic                period_load;
  logic                phase;
  logic [31:0]         rd_mux;
  logic                unused_wd;

  assign wr_req.vld  = chipselect & ~write_n;
  assign wr_req.addr = address;
  assign wr_req.data = writedata;

  // Bits of writedata that lie above the register widths are ignored.
  assign wd        = wr_req.data[WIDTH-1:0];
  assign unused_wd = ^wr_req.data;

  assign period_load = wr_req.vld && (wr_req.addr == ADDR_PERIOD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE[WIDTH-1:0];
      mask_q   <= '0;
      period_q <= '0;
    end else if (wr_req.vld) begin
      case (wr_req.addr)
        ADDR_DATA:     data_q   <= wd;
        ADDR_MASK:     mask_q   <= wd;
        ADDR_PERIOD:   period_q <= wr_req.data[PERIOD_W-1:0];
        ADDR_OUTSET:   data_q   <= data_q | wd;
        ADDR_OUTCLEAR: data_q   <= data_q & ~wd;
        default: ;
      endcase
    end
  end

  nios_security_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .load    (period_load),
    .phase   (phase)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:   rd_mux = 32'(data_q);
      ADDR_MASK:   rd_mux = 32'(mask_q);
      ADDR_PERIOD: rd_mux = 32'(period_q);
      ADDR_STATUS: rd_mux = {31'd0, phase};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= RESET_VALUE[WIDTH-1:0];
    end else begin
      readdata <= rd_mux;
      out_port <= data_q ^ (mask_q & {WIDTH{phase}});
    end
  end

endmodule
